// File: rtl/hamming_sched_pkg.sv
// hamming_sched_pkg: shared state encoding, widths and helpers for the Hamming receive scheduler.
package hamming_sched_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ISSUE   = 3'd1,
        WAIT    = 3'd2,
        CAPTURE = 3'd3,
        OUTPUT  = 3'd4
    } state_e;

    localparam int CODE_W = 7;
    localparam int NIB_W  = 4;
    localparam int SYN_W  = 3;
    localparam int CNT_W  = 8;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// rr_arbiter2: two-request round-robin arbiter; the pointer moves past the winner on accept.
module rr_arbiter2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req_i,
    input  logic       accept_i,
    output logic [1:0] gnt_o,
    output logic       gnt_idx_o
);

    logic ptr_q, ptr_d;

    always_comb begin
        gnt_idx_o = req_i[ptr_q] ? ptr_q : ~ptr_q;
        gnt_o     = (2'b01 << gnt_idx_o) & req_i;
        ptr_d     = accept_i ? ~gnt_idx_o : ptr_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ptr_q <= 1'b0;
        else        ptr_q <= ptr_d;
    end

endmodule

// File: rtl/hamming_rx_scheduler.sv
// hamming_rx_scheduler: shares one Hamming(7,4) decoder between two UART channels and pairs nibbles
// into bytes. Define HAMMING_SCHED_STATS_EN to add per-channel corrected-error counters.
module hamming_rx_scheduler
    import hamming_sched_pkg::*;
#(
    parameter int DEC_LATENCY = 2,
    parameter int NUM_CH      = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_CH-1:0]        req_valid,
    input  logic [NUM_CH*CODE_W-1:0] req_code,
    output logic [NUM_CH-1:0]        req_ready,
    output logic [CODE_W-1:0]        dec_in,
    output logic                     dec_ena,
    input  logic [NIB_W-1:0]         dec_data,
    input  logic [SYN_W-1:0]         dec_syndrome,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [2*NIB_W-1:0]       out_byte,
    output logic                     out_chan,
    output logic                     out_err,
    output logic                     busy
`ifdef HAMMING_SCHED_STATS_EN
    ,
    input  logic                     stats_clr,
    output logic [CNT_W-1:0]         corr_cnt0,
    output logic [CNT_W-1:0]         corr_cnt1
`endif
);

    state_e                  state_q, state_d;
    logic [2:0]              cnt_q, cnt_d;
    logic [CODE_W-1:0]       dec_in_q, dec_in_d;
    logic                    grant_q, grant_d;
    logic [1:0]              pend_q, pend_d;
    logic [1:0]              err_lo_q, err_lo_d;
    logic [1:0][NIB_W-1:0]   lo_q, lo_d;
    logic [2*NIB_W-1:0]      byte_q, byte_d;
    logic                    chan_q, chan_d;
    logic                    err_q, err_d;
    logic [1:0]              gnt, blocked;
    logic                    gnt_idx, hs, syn_err;

    // A channel whose completed byte is waiting in OUTPUT may not be granted again.
    assign blocked   = (state_q == OUTPUT) ? {chan_q, ~chan_q} : 2'b00;
    assign req_ready = (rst_n && state_q == IDLE) ? gnt : 2'b00;
    assign hs        = |(req_valid & req_ready);
    assign syn_err   = |dec_syndrome;

    rr_arbiter2 u_arb (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_i     (req_valid & ~blocked),
        .accept_i  (hs),
        .gnt_o     (gnt),
        .gnt_idx_o (gnt_idx)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        dec_in_d = dec_in_q;
        grant_d  = grant_q;
        pend_d   = pend_q;
        err_lo_d = err_lo_q;
        lo_d     = lo_q;
        byte_d   = byte_q;
        chan_d   = chan_q;
        err_d    = err_q;
        case (state_q)
            IDLE: begin
                if (hs) begin
                    dec_in_d = gnt_idx ? req_code[2*CODE_W-1:CODE_W] : req_code[CODE_W-1:0];
                    grant_d  = gnt_idx;
                    state_d  = ISSUE;
                end
            end
            ISSUE: begin
                cnt_d   = 3'(DEC_LATENCY - 1);
                state_d = WAIT;
            end
            WAIT: begin
                if (cnt_q == 3'd0) state_d = CAPTURE;
                else               cnt_d   = cnt_q - 3'd1;
            end
            CAPTURE: begin
                if (!pend_q[grant_q]) begin
                    lo_d[grant_q]     = dec_data;
                    err_lo_d[grant_q] = syn_err;
                    pend_d[grant_q]   = 1'b1;
                    state_d           = IDLE;
                end else begin
                    byte_d          = {dec_data, lo_q[grant_q]};
                    chan_d          = grant_q;
                    err_d           = err_lo_q[grant_q] | syn_err;
                    pend_d[grant_q] = 1'b0;
                    state_d         = OUTPUT;
                end
            end
            OUTPUT: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            dec_in_q <= '0;
            grant_q  <= 1'b0;
            pend_q   <= '0;
            err_lo_q <= '0;
            lo_q     <= '0;
            byte_q   <= '0;
            chan_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            dec_in_q <= dec_in_d;
            grant_q  <= grant_d;
            pend_q   <= pend_d;
            err_lo_q <= err_lo_d;
            lo_q     <= lo_d;
            byte_q   <= byte_d;
            chan_q   <= chan_d;
            err_q    <= err_d;
        end
    end

    assign dec_in    = dec_in_q;
    assign dec_ena   = (state_q == ISSUE);
    assign out_valid = (state_q == OUTPUT);
    assign out_byte  = byte_q;
    assign out_chan  = chan_q;
    assign out_err   = err_q;
    assign busy      = (state_q != IDLE);

`ifdef HAMMING_SCHED_STATS_EN
    logic [CNT_W-1:0] cc0_q, cc1_q;
    logic             corr;

    assign corr = (state_q == CAPTURE) && syn_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cc0_q <= '0;
            cc1_q <= '0;
        end else if (stats_clr) begin
            cc0_q <= '0;
            cc1_q <= '0;
        end else if (corr) begin
            if (grant_q) cc1_q <= sat_inc(cc1_q);
            else         cc0_q <= sat_inc(cc0_q);
        end
    end

    assign corr_cnt0 = cc0_q;
    assign corr_cnt1 = cc1_q;
`endif

endmodule

// File: doc/hamming_rx_scheduler.md
Name: hamming_rx_scheduler

Overview:
Shares one Hamming(7,4) decoder between two UART receive channels. Arbitrates codeword requests round-robin and sequences the decoder (drive input, pulse enable, wait a fixed latency, capture the result). Pairs decoded nibbles per channel (low nibble first) into bytes and presents them on one backpressured output stream tagged with channel and error status. Sits between the UART receivers and the byte sink.

Parameters:
DEC_LATENCY, 2, cycles from the dec_ena pulse to valid dec_data/dec_syndrome; legal range 1..7.
NUM_CH, 2, number of requesting channels; fixed at 2 in this revision.

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
req_valid  input  2  per-channel codeword available
req_code  input  14  per-channel 7-bit codeword; ch0 = [6:0], ch1 = [13:7]
req_ready  output  2  per-channel accept; a handshake occurs when valid && ready
dec_in  output  7  codeword driven to the decoder
dec_ena  output  1  one-cycle decoder enable pulse
dec_data  input  4  decoded nibble
dec_syndrome  input  3  decoder syndrome (nonzero = corrected error)
out_valid  output  1  assembled byte available
out_ready  input  1  sink accept
out_byte  output  8  {high nibble, low nibble}
out_chan  output  1  source channel of out_byte
out_err  output  1  either nibble had a nonzero syndrome
busy  output  1  FSM not in IDLE

Behaviour:
- Reset value of all outputs is 0; rr_ptr = 0; both nibble-pending flags cleared; FSM = IDLE.
- FSM states: IDLE, ISSUE, WAIT, CAPTURE, OUTPUT.
- IDLE:
  - Grant one channel with req_valid = 1 that is not blocked. Priority starts at rr_ptr.
  - A channel is blocked while its pending byte is complete and sitting in OUTPUT.
  - Assert req_ready for exactly the granted channel, combinationally, in this cycle only.
  - On the handshake: latch the codeword into the dec_in register, record grant_ch, set rr_ptr = ~grant_ch, go to ISSUE.
- ISSUE: dec_ena = 1 for exactly one cycle; load the wait counter with DEC_LATENCY-1; go to WAIT.
- WAIT: decrement the counter each cycle. When it reaches 0 (DEC_LATENCY cycles after the dec_ena cycle), go to CAPTURE.
- CAPTURE: sample dec_data and dec_syndrome.
  - If the channel has no pending low nibble: store dec_data as the low nibble, set pending, record err_lo = |syndrome, go to IDLE.
  - Otherwise: form the byte and err = err_lo | |syndrome, clear pending, go to OUTPUT.
- OUTPUT: out_valid = 1; out_byte/out_chan/out_err are stable until out_valid && out_ready. On that handshake go to IDLE; out_valid drops the next cycle.
- Throughput: at most one codeword per DEC_LATENCY+3 cycles. Zero-wait sink gives one byte per 2*(DEC_LATENCY+3)+1 cycles for one channel.
- Simultaneous req_valid on both channels: rr_ptr decides. Strict alternation is required when both stay valid.
- Pending low nibbles are held per channel. Interleaved codewords from ch0 and ch1 assemble independently.
- dec_in holds its value from ISSUE through CAPTURE. dec_ena = 0 in every other state.
- Reset mid-operation: the FSM aborts to IDLE, partial nibbles are discarded, and any byte in OUTPUT is dropped without a handshake.
- req_valid dropping without a handshake is allowed; no state change results.

Optional Feature:
HAMMING_SCHED_STATS_EN.
- When defined, the block adds these outputs:
  - corr_cnt0 (8 bits): count of ch0 nonzero syndromes, incremented in CAPTURE, saturating at 255.
  - corr_cnt1 (8 bits): the same for ch1.
  - stats_clr (input, 1 bit): synchronous clear of both counters. Clear wins over a same-cycle increment.
- When not defined, these ports and registers are absent; all other behaviour is identical.

Decomposition:
- Package hamming_sched_pkg holds:
  - the state enum (IDLE=0, ISSUE=1, WAIT=2, CAPTURE=3, OUTPUT=4), 3 bits;
  - the CODE_W=7, NIB_W=4 and SYN_W=3 constants;
  - the counter width constant CNT_W=8.
- Sub-module rr_arbiter2: 2-request round-robin grant with pointer update on accept. It is natural to split out for reuse and isolated verification.

Test Plan:
- Single channel, with a decoder model of latency 2:
  - Stimulus: ch0 sends codewords decoding to 0x5, then 0xA; out_ready = 1.
  - Response: out_byte = 0xA5, out_chan = 0, out_err = 0. Exactly two dec_ena pulses, 5 cycles apart from handshake to CAPTURE.
- Contention:
  - Stimulus: both channels are held valid; ch0 nibbles 1,2; ch1 nibbles 3,4.
  - Response: grants alternate 0,1,0,1; outputs are 0x21 (ch0) then 0x43 (ch1).
- Error flag:
  - Stimulus: the second nibble returns syndrome 3'b011.
  - Response: out_err = 1; with HAMMING_SCHED_STATS_EN, corr_cnt0 = 1.
- Backpressure:
  - Stimulus: out_ready = 0 for 10 cycles with a byte in OUTPUT.
  - Response: out_* stable, req_ready = 00 throughout; the byte is delivered on the first out_ready = 1.
- Reset mid-WAIT:
  - Stimulus: assert rst_n = 0 with a pending low nibble.
  - Response: all outputs 0. After release, a fresh nibble pair yields a byte built only from the new nibbles.
- Saturation:
  - Stimulus: 300 erroneous codewords on ch1.
  - Response: corr_cnt1 = 255. stats_clr together with an error in the same cycle gives 0.
